// File: rtl/pkt_tx_arbiter.sv
// Round-robin merge of NUM_SRC single-beat packet streams into one output
// register, with a credit limit on packets granted but not yet acknowledged
// by a tx status beat, a saturating error-status counter, and a sticky
// underflow flag for statuses that arrive with no credit in use.
module pkt_tx_arbiter #(
  parameter int NUM_SRC         = 4,
  parameter int MAX_OUTSTANDING = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_SRC*544-1:0] s_pkt_TDATA,
  input  logic [NUM_SRC-1:0]     s_pkt_TVALID,
  output logic [NUM_SRC-1:0]     s_pkt_TREADY,
  output logic [543:0]           m_pkt_TDATA,
  output logic                   m_pkt_TVALID,
  input  logic                   m_pkt_TREADY,
  input  logic                   tx_status_TVALID,
  input  logic                   tx_status_TREADY,
  input  logic                   tx_status_err,
  output logic [7:0]             outstanding,
  output logic [31:0]            err_count,
  output logic                   underflow
);

  localparam int unsigned PKT_W = 544;
  localparam int unsigned PW    = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  localparam logic [7:0]    MAX_OUT  = 8'(MAX_OUTSTANDING);
  localparam logic [PW-1:0] LAST_SRC = PW'(NUM_SRC - 1);
  localparam logic [PW:0]   N_EXT    = (PW + 1)'(NUM_SRC);

  // Registered state
  logic [PKT_W-1:0] m_data_q, m_data_d;
  logic             m_valid_q, m_valid_d;
  logic [PW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [7:0]       outstanding_q, outstanding_d;
  logic [31:0]      err_count_q, err_count_d;
  logic             underflow_q, underflow_d;

  // Arbitration terms
  logic             load;
  logic             credit_ok;
  logic             any_valid;
  logic             grant;
  logic             st_fire;
  logic [PW-1:0]    sel;
  logic [PW-1:0]    offs;
  logic [PW:0]      sel_sum;
  logic [NUM_SRC-1:0] valid_rot;
  logic [PKT_W-1:0] sel_data;

  assign load      = !m_valid_q || m_pkt_TREADY;
  // Credit uses the registered count only: a status in this cycle frees credit next cycle.
  assign credit_ok = outstanding_q < MAX_OUT;
  // rst gates the grant so no upstream handshake can complete while in reset.
  assign grant     = !rst && load && credit_ok && any_valid;
  assign st_fire   = tx_status_TVALID && tx_status_TREADY;

  // Round-robin search: rotate valids so rr_ptr lands at bit 0, take the first
  // set bit, then map the offset back to a source index modulo NUM_SRC.
  always_comb begin
    valid_rot = NUM_SRC'({s_pkt_TVALID, s_pkt_TVALID} >> rr_ptr_q);
    any_valid = 1'b0;
    offs      = '0;
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      if (!any_valid && valid_rot[k]) begin
        any_valid = 1'b1;
        offs      = PW'(k);
      end
    end
    sel_sum = {1'b0, rr_ptr_q} + {1'b0, offs};
    if (sel_sum >= N_EXT) begin
      sel_sum = sel_sum - N_EXT;
    end
    sel = sel_sum[PW-1:0];
  end

  // Data mux and one-hot ready for the selected source.
  always_comb begin
    sel_data     = '0;
    s_pkt_TREADY = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (sel == PW'(i)) begin
        sel_data        = s_pkt_TDATA[i*PKT_W +: PKT_W];
        s_pkt_TREADY[i] = grant;
      end
    end
  end

  // Output register and round-robin pointer next state.
  always_comb begin
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    rr_ptr_d  = rr_ptr_q;
    if (grant) begin
      m_valid_d = 1'b1;
      m_data_d  = sel_data;
      rr_ptr_d  = (sel == LAST_SRC) ? '0 : sel + PW'(1);
    end else if (load) begin
      m_valid_d = 1'b0;
    end
  end

  // Credit counter and sticky underflow on a status with nothing outstanding.
  always_comb begin
    outstanding_d = outstanding_q;
    underflow_d   = underflow_q;
    if (grant && !st_fire) begin
      outstanding_d = outstanding_q + 8'd1;
    end else if (!grant && st_fire) begin
      if (outstanding_q == '0) begin
        underflow_d = 1'b1;
      end else begin
        outstanding_d = outstanding_q - 8'd1;
      end
    end
  end

  // Saturating count of error statuses.
  always_comb begin
    err_count_d = err_count_q;
    if (st_fire && tx_status_err && (err_count_q != '1)) begin
      err_count_d = err_count_q + 32'd1;
    end
  end

  // State registers, asynchronously cleared.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_data_q      <= '0;
      m_valid_q     <= 1'b0;
      rr_ptr_q      <= '0;
      outstanding_q <= '0;
      err_count_q   <= '0;
      underflow_q   <= 1'b0;
    end else begin
      m_data_q      <= m_data_d;
      m_valid_q     <= m_valid_d;
      rr_ptr_q      <= rr_ptr_d;
      outstanding_q <= outstanding_d;
      err_count_q   <= err_count_d;
      underflow_q   <= underflow_d;
    end
  end

  assign m_pkt_TDATA  = m_data_q;
  assign m_pkt_TVALID = m_valid_q;
  assign outstanding  = outstanding_q;
  assign err_count    = err_count_q;
  assign underflow    = underflow_q;

endmodule

// File: tb/tb_pkt_tx_arbiter.sv
// Directed bench for pkt_tx_arbiter: a default instance (16 credits) and a
// 4-credit instance share all inputs.
module tb_pkt_tx_arbiter;

  localparam int N = 4;
  localparam int W = 544;

  logic           clk = 1'b0;
  logic           rst;
  logic [N*W-1:0] s_data;
  logic [N-1:0]   s_valid;
  logic [N-1:0]   s_ready, s_ready4;
  logic [W-1:0]   m_data, m_data4;
  logic           m_valid, m_valid4;
  logic           m_ready;
  logic           st_valid, st_ready, st_err;
  logic [7:0]     outst, outst4;
  logic [31:0]    err_cnt, err_cnt4;
  logic           uflow, uflow4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pkt_tx_arbiter #(.NUM_SRC(N), .MAX_OUTSTANDING(16)) dut (
    .clk(clk), .rst(rst),
    .s_pkt_TDATA(s_data), .s_pkt_TVALID(s_valid), .s_pkt_TREADY(s_ready),
    .m_pkt_TDATA(m_data), .m_pkt_TVALID(m_valid), .m_pkt_TREADY(m_ready),
    .tx_status_TVALID(st_valid), .tx_status_TREADY(st_ready), .tx_status_err(st_err),
    .outstanding(outst), .err_count(err_cnt), .underflow(uflow)
  );

  pkt_tx_arbiter #(.NUM_SRC(N), .MAX_OUTSTANDING(4)) dut4 (
    .clk(clk), .rst(rst),
    .s_pkt_TDATA(s_data), .s_pkt_TVALID(s_valid), .s_pkt_TREADY(s_ready4),
    .m_pkt_TDATA(m_data4), .m_pkt_TVALID(m_valid4), .m_pkt_TREADY(m_ready),
    .tx_status_TVALID(st_valid), .tx_status_TREADY(st_ready), .tx_status_err(st_err),
    .outstanding(outst4), .err_count(err_cnt4), .underflow(uflow4)
  );

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] pkt(input int i);
    logic [W-1:0] p;
    p            = '0;
    p[527:512]   = 16'h0100 + 16'(i);
    p[511:448]   = ~64'(i);
    p[63:0]      = 64'hC0DE_0000_0000_0000 + 64'(i);
    return p;
  endfunction

  // Advance to 2 time units after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    s_valid  = '0;
    st_valid = 1'b0;
    st_ready = 1'b0;
    st_err   = 1'b0;
    rst = 1'b1;
    #1;
    rst = 1'b0;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] exp_rdy;
    logic [2:0] ev  [6];
    int         exp_err [6];
    ev      = '{3'b111, 3'b110, 3'b101, 3'b111, 3'b110, 3'b111};
    exp_err = '{1, 1, 1, 2, 2, 3};

    rst = 1'b1; s_valid = '0; m_ready = 1'b0;
    st_valid = 1'b0; st_ready = 1'b0; st_err = 1'b0;
    for (int i = 0; i < N; i++) s_data[i*W +: W] = pkt(i);
    repeat (2) cyc();

    // Reset state, sources requesting during reset get no ready
    s_valid = 4'hF;
    #1;
    check("rst_mvalid", W'(m_valid), W'(0));
    check("rst_mdata", m_data, '0);
    check("rst_sready", W'(s_ready), W'(0));
    check("rst_outst", W'(outst), W'(0));
    check("rst_errcnt", W'(err_cnt), W'(0));
    check("rst_uflow", W'(uflow), W'(0));
    s_valid = '0;
    rst = 1'b0;

    // Round robin with a status every cycle
    m_ready = 1'b1; s_valid = 4'hF; st_valid = 1'b1; st_ready = 1'b1;
    #1;
    for (int k = 0; k < 8; k++) begin
      exp_rdy = 4'b0001 << (k % 4);
      check("rr_ready", W'(s_ready), W'(exp_rdy));
      cyc();
      check("rr_valid", W'(m_valid), W'(1));
      check("rr_data", m_data, pkt(k % 4));
      check("rr_outst", W'(outst), W'(0));
    end
    check("rr_uflow", W'(uflow), W'(0));
    s_valid = '0; st_valid = 1'b0; st_ready = 1'b0;
    cyc();
    check("rr_drain", W'(m_valid), W'(0));

    // Backpressure: sources 1 and 3
    do_reset();
    m_ready = 1'b0; s_valid = 4'b1010;
    #1;
    check("bp_first_ready", W'(s_ready), W'(4'b0010));
    cyc();
    for (int k = 0; k < 5; k++) begin
      check("bp_hold_ready", W'(s_ready), W'(0));
      check("bp_hold_data", m_data, pkt(1));
      check("bp_hold_valid", W'(m_valid), W'(1));
      cyc();
    end
    m_ready = 1'b1;
    #1;
    check("bp_rel_ready3", W'(s_ready), W'(4'b1000));
    cyc();
    check("bp_data3", m_data, pkt(3));
    check("bp_rel_ready1", W'(s_ready), W'(4'b0010));
    cyc();
    check("bp_data1", m_data, pkt(1));
    check("bp_rel_ready3b", W'(s_ready), W'(4'b1000));
    cyc();
    check("bp_data3b", m_data, pkt(3));
    check("bp_outst", W'(outst), W'(4));
    s_valid = '0;
    cyc();
    check("bp_drain", W'(m_valid), W'(0));

    // Credit stall on the 4-credit instance, source 2 streaming
    do_reset();
    m_ready = 1'b1; s_valid = 4'b0100;
    #1;
    for (int k = 0; k < 4; k++) begin
      check("cs_ready", W'(s_ready4), W'(4'b0100));
      cyc();
      check("cs_valid", W'(m_valid4), W'(1));
      check("cs_data", m_data4, pkt(2));
      check("cs_outst", W'(outst4), W'(k + 1));
    end
    check("cs_stall_ready", W'(s_ready4), W'(0));
    cyc();
    check("cs_stall_valid", W'(m_valid4), W'(0));
    check("cs_stall_outst", W'(outst4), W'(4));
    st_valid = 1'b1; st_ready = 1'b1;
    #1;
    check("cs_full_st_ready", W'(s_ready4), W'(0));
    cyc();
    st_valid = 1'b0; st_ready = 1'b0;
    #1;
    check("cs_freed_outst", W'(outst4), W'(3));
    check("cs_freed_valid", W'(m_valid4), W'(0));
    check("cs_freed_ready", W'(s_ready4), W'(4'b0100));
    cyc();
    check("cs_extra_valid", W'(m_valid4), W'(1));
    check("cs_extra_outst", W'(outst4), W'(4));
    check("cs_extra_ready", W'(s_ready4), W'(0));
    // Grant plus status at MAX-1
    s_valid = '0; st_valid = 1'b1; st_ready = 1'b1;
    cyc();
    check("cs_m1_outst", W'(outst4), W'(3));
    s_valid = 4'b0100;
    #1;
    check("cs_m1_ready", W'(s_ready4), W'(4'b0100));
    cyc();
    check("cs_m1_keep", W'(outst4), W'(3));
    check("cs_m1_valid", W'(m_valid4), W'(1));
    s_valid = '0; st_valid = 1'b0; st_ready = 1'b0;
    cyc();

    // Error counting, including a status with TREADY low
    do_reset();
    for (int i = 0; i < 6; i++) begin
      {st_valid, st_ready, st_err} = ev[i];
      cyc();
      check("err_count", W'(err_cnt), W'(exp_err[i]));
    end
    st_valid = 1'b0; st_ready = 1'b0; st_err = 1'b0;

    // Underflow and persistence
    do_reset();
    check("uf_clear", W'(uflow), W'(0));
    st_valid = 1'b1; st_ready = 1'b1;
    cyc();
    st_valid = 1'b0; st_ready = 1'b0;
    check("uf_outst", W'(outst), W'(0));
    check("uf_set", W'(uflow), W'(1));
    s_valid = 4'b0001;
    repeat (2) cyc();
    check("uf_outst2", W'(outst), W'(2));
    check("uf_persist", W'(uflow), W'(1));
    s_valid = '0;
    cyc();
    check("uf_persist2", W'(uflow), W'(1));
    do_reset();
    check("uf_rst", W'(uflow), W'(0));

    // Reset mid-stream at outstanding 7
    s_valid = 4'hF;
    repeat (7) cyc();
    check("ms_valid", W'(m_valid), W'(1));
    check("ms_outst", W'(outst), W'(7));
    check("ms_data", m_data, pkt(2));
    rst = 1'b1;
    #1;
    check("ms_rst_valid", W'(m_valid), W'(0));
    check("ms_rst_data", m_data, '0);
    check("ms_rst_outst", W'(outst), W'(0));
    check("ms_rst_ready", W'(s_ready), W'(0));
    s_valid = 4'b0110;
    #1;
    check("ms_rst_ready2", W'(s_ready), W'(0));
    rst = 1'b0;
    #1;
    check("ms_rec_ready", W'(s_ready), W'(4'b0010));
    cyc();
    check("ms_rec_data", m_data, pkt(1));
    check("ms_rec_outst", W'(outst), W'(1));
    s_valid = '0;
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
